// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the M-stage data-memory controller and its
// byte-enable generator: opcodes, FSM encoding, byte-enable constants.
package mem_ctrl_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [OP_W-1:0] OP_LW = 6'b100011;
  localparam logic [OP_W-1:0] OP_LH = 6'b100001;
  localparam logic [OP_W-1:0] OP_LB = 6'b100000;
  localparam logic [OP_W-1:0] OP_SW = 6'b101011;
  localparam logic [OP_W-1:0] OP_SH = 6'b101001;
  localparam logic [OP_W-1:0] OP_SB = 6'b101000;

  localparam logic [BE_W-1:0] BE_NONE    = 4'b0000;
  localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;
  localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
  localparam logic [BE_W-1:0] BE_BYTE0   = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Command held on the data bus for the whole transaction
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

endpackage

// File: rtl/m_be_gen.sv
// Decodes a load/store opcode into access type, alignment check,
// byte enables and lane-replicated store data.
module m_be_gen
  import mem_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]   opcode,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  output logic              is_load,
  output logic              is_store,
  output logic              misaligned,
  output logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] wdata_steered
);

  always_comb begin
    is_load       = 1'b0;
    is_store      = 1'b0;
    misaligned    = 1'b0;
    be            = BE_NONE;
    wdata_steered = wdata;
    case (opcode)
      OP_LW, OP_SW: begin
        is_load    = (opcode == OP_LW);
        is_store   = (opcode == OP_SW);
        misaligned = |addr_lo;
        be         = BE_WORD;
      end
      OP_LH, OP_SH: begin
        is_load       = (opcode == OP_LH);
        is_store      = (opcode == OP_SH);
        misaligned    = addr_lo[0];
        be            = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_steered = {2{wdata[15:0]}};
      end
      OP_LB, OP_SB: begin
        is_load       = (opcode == OP_LB);
        is_store      = (opcode == OP_SB);
        be            = BE_BYTE0 << addr_lo;
        wdata_steered = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/m_mem_ctrl.sv
// M-stage data-memory access controller: accepts an aligned load/store,
// runs one req/ack bus transaction with timeout, stalls the pipeline meanwhile.
module m_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [BE_W-1:0]   bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic              bus_err
);

  logic              is_load;
  logic              is_store;
  logic              misaligned;
  logic [BE_W-1:0]   be_c;
  logic [DATA_W-1:0] wdata_c;
  logic              unused_instr;

  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              ld_q;
  bus_cmd_t          cmd_q;

  logic              accept;
  logic              ack_hit;
  logic              tmo_hit;
  logic              cnt_last;

  assign unused_instr = ^instr[25:0];

  m_be_gen u_be_gen (
    .opcode        (instr[31:26]),
    .addr_lo       (addr[1:0]),
    .wdata         (wdata),
    .is_load       (is_load),
    .is_store      (is_store),
    .misaligned    (misaligned),
    .be            (be_c),
    .wdata_steered (wdata_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (ack_hit || tmo_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Decode of the current state; everything is held quiet while reset is low
  always_comb begin
    accept   = 1'b0;
    stall    = 1'b0;
    exc_adel = 1'b0;
    exc_ades = 1'b0;
    ack_hit  = 1'b0;
    tmo_hit  = 1'b0;
    cnt_last = (cnt_q == CNT_W'(TIMEOUT - 1));
    case (state_q)
      ST_IDLE: begin
        if (reset) begin
          accept   = (is_load | is_store) & ~misaligned;
          exc_adel = is_load & misaligned;
          exc_ades = is_store & misaligned;
          stall    = accept;
        end
      end
      ST_BUSY: begin
        stall   = 1'b1;
        ack_hit = bus_ack;
        tmo_hit = ~bus_ack & cnt_last;
      end
      default: ;
    endcase
  end

  // Bus command, timeout counter and read-return registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q       <= '0;
      bus_req     <= 1'b0;
      cnt_q       <= '0;
      ld_q        <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
      if (accept) begin
        cmd_q.addr  <= {addr[31:2], 2'b00};
        cmd_q.we    <= is_store;
        cmd_q.be    <= be_c;
        cmd_q.wdata <= wdata_c;
        bus_req     <= 1'b1;
        cnt_q       <= '0;
        ld_q        <= is_load;
      end else if (ack_hit) begin
        bus_req     <= 1'b0;
        rdata_valid <= ld_q;
        if (ld_q) rdata <= bus_rdata;
      end else if (tmo_hit) begin
        bus_req     <= 1'b0;
        rdata       <= '0;
        rdata_valid <= ld_q;
        bus_err     <= 1'b1;
      end else if (state_q == ST_BUSY) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus_addr  = cmd_q.addr;
  assign bus_we    = cmd_q.we;
  assign bus_be    = cmd_q.be;
  assign bus_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_m_mem_ctrl.sv
// Self-checking bench for m_mem_ctrl: table of directed load/store
// transactions plus hand-written reset and stray-ack sequences.
module tb_m_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam logic [5:0] NOP = 6'b000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, addr, wdata;
  logic        stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, rdata;
  logic [3:0]  bus_be;
  logic        bus_ack, rdata_valid, exc_adel, exc_ades, bus_err;

  int pass_n  = 0;
  int total_n = 0;

  m_mem_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .exc_adel    (exc_adel),
    .exc_ades    (exc_ades),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] wd;
    int          ack_at;   // BUSY cycle (1-based) carrying bus_ack, 0 = never
    logic [31:0] rd;
    int          stall_n;
    int          req_n;
    logic [3:0]  be;
    logic        we;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    int          rv_n;     // -1 = not checked
    logic [31:0] rdata;
    int          err_n;
    logic        adel;
    logic        ades;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Presents one instruction in IDLE and follows it to the cycle after DONE
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rd,
                        output int stall_n, output int req_n, output int rv_n, output int err_n,
                        output logic [3:0] be, output logic we, output logic [31:0] baddr,
                        output logic [31:0] bwdata, output logic [31:0] rdv,
                        output logic adel, output logic ades, output bit tmo);
    stall_n = 0; req_n = 0; rv_n = 0; err_n = 0;
    be = '0; we = 1'b0; baddr = '0; bwdata = '0; rdv = '0;
    adel = 1'b0; ades = 1'b0; tmo = 1'b1;
    instr = {op, 26'h1234567}; addr = a; wdata = wd; bus_ack = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (c == 0) begin adel = exc_adel; ades = exc_ades; end
      if (stall) stall_n++;
      if (bus_req) begin
        req_n++;
        be = bus_be; we = bus_we; baddr = bus_addr; bwdata = bus_wdata;
      end
      if (rdata_valid) rv_n++;
      if (bus_err) err_n++;
      bus_ack   = bus_req && (req_n == ack_at);
      bus_rdata = rd;
      if (!stall) begin
        rdv   = rdata;
        tmo   = 1'b0;
        instr = {NOP, 26'h0};
        @(posedge clk); #1;
        bus_ack = 1'b0;
        break;
      end
      @(posedge clk);
    end
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_n, r_n, v_n, e_n;
    logic [3:0]  g_be;
    logic        g_we, g_adel, g_ades;
    logic [31:0] g_addr, g_wd, g_rd;
    bit          g_tmo;

    //           op     addr          wdata         ack rd            st req be     we    baddr         bwdata        rv rdata         err adel  ades
    vecs.push_back('{OP_LW, 32'h0000_1004, 32'h0,        3, 32'hDEADBEEF, 4, 3,  4'hF, 1'b0, 32'h0000_1004, 32'h0,        1, 32'hDEADBEEF, 0, 1'b0, 1'b0});
    vecs.push_back('{OP_SB, 32'h0000_2003, 32'h123456A5, 1, 32'h0,        2, 1,  4'h8, 1'b1, 32'h0000_2000, 32'hA5A5A5A5, 0, 32'hDEADBEEF, 0, 1'b0, 1'b0});
    vecs.push_back('{OP_LH, 32'h0000_0003, 32'h0,        1, 32'h0,        0, 0,  4'h0, 1'b0, 32'h0,         32'h0,        0, 32'hDEADBEEF, 0, 1'b1, 1'b0});
    vecs.push_back('{OP_SW, 32'h0000_0002, 32'h0,        1, 32'h0,        0, 0,  4'h0, 1'b0, 32'h0,         32'h0,        0, 32'hDEADBEEF, 0, 1'b0, 1'b1});
    vecs.push_back('{OP_SH, 32'h0000_0006, 32'hCAFEBEEF, 2, 32'h0,        3, 2,  4'hC, 1'b1, 32'h0000_0004, 32'hBEEFBEEF, 0, 32'hDEADBEEF, 0, 1'b0, 1'b0});
    vecs.push_back('{OP_LB, 32'h0000_1001, 32'h0,        1, 32'h11223344, 2, 1,  4'h2, 1'b0, 32'h0000_1000, 32'h0,        1, 32'h11223344, 0, 1'b0, 1'b0});
    vecs.push_back('{OP_LB, 32'h0000_1002, 32'h0,        1, 32'h55667788, 2, 1,  4'h4, 1'b0, 32'h0000_1000, 32'h0,        1, 32'h55667788, 0, 1'b0, 1'b0});
    vecs.push_back('{OP_LH, 32'h0000_2002, 32'h0,        1, 32'hAAAA5555, 2, 1,  4'hC, 1'b0, 32'h0000_2000, 32'h0,        1, 32'hAAAA5555, 0, 1'b0, 1'b0});
    vecs.push_back('{NOP,   32'h0000_1004, 32'h0,        1, 32'h0,        0, 0,  4'h0, 1'b0, 32'h0,         32'h0,        0, 32'hAAAA5555, 0, 1'b0, 1'b0});
    vecs.push_back('{OP_LW, 32'h0000_1000, 32'h0,        0, 32'hFFFFFFFF, 17, 16, 4'hF, 1'b0, 32'h0000_1000, 32'h0,       -1, 32'h0,        1, 1'b0, 1'b0});
    vecs.push_back('{OP_SW, 32'h0000_0008, 32'h01020304, 1, 32'h0,        2, 1,  4'hF, 1'b1, 32'h0000_0008, 32'h01020304, 0, 32'h0,        0, 1'b0, 1'b0});
    vecs.push_back('{OP_LW, 32'h0000_1001, 32'h0,        1, 32'h0,        0, 0,  4'h0, 1'b0, 32'h0,         32'h0,        0, 32'h0,        0, 1'b1, 1'b0});
    vecs.push_back('{OP_SH, 32'h0000_0001, 32'h0,        1, 32'h0,        0, 0,  4'h0, 1'b0, 32'h0,         32'h0,        0, 32'h0,        0, 1'b0, 1'b1});
    vecs.push_back('{OP_LW, 32'h0000_3000, 32'h0,        2, 32'h13579BDF, 3, 2,  4'hF, 1'b0, 32'h0000_3000, 32'h0,        1, 32'h13579BDF, 0, 1'b0, 1'b0});

    reset = 1'b0; instr = {NOP, 26'h0}; addr = '0; wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].wd, vecs[i].ack_at, vecs[i].rd,
             s_n, r_n, v_n, e_n, g_be, g_we, g_addr, g_wd, g_rd, g_adel, g_ades, g_tmo);
      chk($sformatf("v%0d_timeout", i), 32'(g_tmo), 32'd0);
      chk($sformatf("v%0d_stall_cycles", i), 32'(s_n), 32'(vecs[i].stall_n));
      chk($sformatf("v%0d_req_cycles", i), 32'(r_n), 32'(vecs[i].req_n));
      chk($sformatf("v%0d_exc_adel", i), 32'(g_adel), 32'(vecs[i].adel));
      chk($sformatf("v%0d_exc_ades", i), 32'(g_ades), 32'(vecs[i].ades));
      chk($sformatf("v%0d_bus_err", i), 32'(e_n), 32'(vecs[i].err_n));
      chk($sformatf("v%0d_rdata", i), g_rd, vecs[i].rdata);
      if (vecs[i].rv_n >= 0)
        chk($sformatf("v%0d_rdata_valid", i), 32'(v_n), 32'(vecs[i].rv_n));
      if (vecs[i].req_n > 0) begin
        chk($sformatf("v%0d_bus_be", i), 32'(g_be), 32'(vecs[i].be));
        chk($sformatf("v%0d_bus_we", i), 32'(g_we), 32'(vecs[i].we));
        chk($sformatf("v%0d_bus_addr", i), g_addr, vecs[i].baddr);
        if (vecs[i].we)
          chk($sformatf("v%0d_bus_wdata", i), g_wd, vecs[i].bwdata);
      end
    end

    // Stray ack while idle must not update rdata or signal completion
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("idle_ack_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("idle_ack_rdata", rdata, 32'h13579BDF);
    chk("idle_ack_stall", 32'(stall), 32'd0);

    // Reset asserted in the second BUSY cycle of an unacknowledged load
    instr = {OP_LW, 26'h0}; addr = 32'h0000_0040;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy_req", 32'(bus_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_bus_req", 32'(bus_req), 32'd0);
    chk("async_rst_stall", 32'(stall), 32'd0);
    chk("async_rst_bus_addr", bus_addr, 32'h0);
    chk("async_rst_bus_be", 32'(bus_be), 32'd0);
    chk("async_rst_rdata", rdata, 32'h0);
    instr = {NOP, 26'h0};
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("post_rst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("post_rst_rdata", rdata, 32'h0);
    chk("post_rst_bus_req", 32'(bus_req), 32'd0);
    chk("post_rst_stall", 32'(stall), 32'd0);

    run_op(OP_SH, 32'h0000_0002, 32'h0000_BEEF, 1, 32'h0,
           s_n, r_n, v_n, e_n, g_be, g_we, g_addr, g_wd, g_rd, g_adel, g_ades, g_tmo);
    chk("fresh_sh_timeout", 32'(g_tmo), 32'd0);
    chk("fresh_sh_be", 32'(g_be), 32'hC);
    chk("fresh_sh_we", 32'(g_we), 32'd1);
    chk("fresh_sh_addr", g_addr, 32'h0);
    chk("fresh_sh_wdata", g_wd, 32'hBEEFBEEF);
    chk("fresh_sh_stall_cycles", 32'(s_n), 32'd2);
    chk("fresh_sh_rdata_valid", 32'(v_n), 32'd0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/m_mem_ctrl.md
Name: m_mem_ctrl

Overview:
- Memory-stage data-memory access controller for the 5-stage MIPS pipeline.
- Accepts the load/store in M, checks alignment and builds word address, byte enables and lane-steered write data.
- Runs a req/ack transaction on a multi-cycle data bus, stalling the pipeline until done.
- Hands the raw read word to the M-stage load-extension logic.

Parameters:
- TIMEOUT, 16, max BUSY cycles waiting for bus_ack before aborting with bus_err (≥2)
- CNT_W, 5, width of timeout counter; must hold TIMEOUT

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- instr  in  32  instruction currently in M
- addr  in  32  effective address from ALU
- wdata  in  32  store data (rt, forwarded)
- stall  out  1  freeze F/D/E/M; combinational
- bus_req  out  1  transaction request, registered
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-steered write data
- bus_ack  in  1  transaction complete (1-cycle pulse)
- bus_rdata  in  32  read word, valid with bus_ack
- rdata  out  32  captured read word to load extension
- rdata_valid  out  1  1-cycle pulse, load finished
- exc_adel  out  1  load address error, combinational
- exc_ades  out  1  store address error, combinational
- bus_err  out  1  1-cycle pulse on timeout

Behaviour:
- Ops by instr[31:26]: lw 100011, lh 100001, lb 100000, sw 101011, sh 101001, sb 101000; all others are non-memory.
- Misaligned: lw/sw addr[1:0]≠0; lh/sh addr[0]≠0. Raises exc_adel (loads) or exc_ades (stores) while in IDLE. No bus access, no stall.
- accept = IDLE & memory op & aligned.
- FSM states: IDLE, BUSY, DONE.
  - IDLE→BUSY on accept. Registers bus_addr, bus_we, bus_be, bus_wdata; sets bus_req=1; clears counter.
  - BUSY, bus_ack=1 → DONE. bus_req←0; rdata←bus_rdata for loads, unchanged for stores.
  - BUSY, no ack, counter==TIMEOUT-1 → DONE. bus_req←0; rdata←0; bus_err pulses in DONE.
  - BUSY, otherwise: counter+1.
  - DONE→IDLE unconditionally. rdata_valid=1 for loads only. DONE never accepts, so the same instr is not reissued.
- stall = (IDLE & accept) | BUSY; 0 in DONE so the pipeline advances.
- Minimum latency: 2 stall cycles (ack in the first BUSY cycle). Back-to-back memory ops start a new accept in the IDLE cycle after DONE.
- Byte enables:
  - sw/lw: 1111.
  - sh/lh: addr[1] ? 1100 : 0011.
  - sb/lb: 0001<<addr[1:0].
  - Loads drive the same BE as stores, with bus_we=0.
- Write data steering: sh → {2{wdata[15:0]}}; sb → {4{wdata[7:0]}}; sw → wdata.
- bus_ack outside BUSY is ignored.
- Reset (any time, including mid-BUSY):
  - State IDLE, counter 0.
  - bus_req, bus_we, rdata_valid, bus_err = 0; bus_be = 0; bus_addr, bus_wdata, rdata = 0.
  - An abandoned bus transaction is not completed.
- bus_addr/be/we/wdata hold stable from entry to BUSY until leaving BUSY.

Decomposition:
- Shared package mem_ctrl_pkg:
  - opcode constants (OP_LW/LH/LB/SW/SH/SB)
  - FSM state encoding (2 bits)
  - BE constants
- Sub-module m_be_gen: combinational. Inputs opcode and addr[1:0]. Outputs is_load, is_store, misaligned, be[3:0], and steered wdata. Reused later by a store-buffer block.

Test Plan:
- lw addr 0x0000_1004, bus_ack 3 cycles after bus_req rises, bus_rdata 0xDEADBEEF → bus_be=1111, bus_addr 0x1004, stall high 4 cycles, rdata=0xDEADBEEF, rdata_valid 1 cycle.
- sb addr 0x0000_2003, wdata 0x1234_56A5, ack immediately → bus_we=1, bus_be=1000, bus_wdata=0xA5A5A5A5, stall exactly 2 cycles, no rdata_valid.
- lh addr 0x0000_0003 → exc_adel=1 same cycle, stall=0, bus_req never rises. sw addr 0x0000_0002 → exc_ades=1, no bus activity.
- lw with TIMEOUT=16 and no ack → bus_req high 16 cycles, bus_err pulse, rdata=0, stall released.
- reset driven low in the second BUSY cycle → bus_req, stall, all outputs 0 asynchronously. A later bus_ack is ignored. After reset is released, a fresh sh to 0x0000_0002 yields be=1100.
- Back-to-back lb 0x1001 then lb 0x1002, each acked immediately → be 0010 then 0100, each load issues exactly once, 2 stall cycles each.
